dispatch_unit: RTL and testbench
================================

DISPATCH_UNIT -- requirements
Module: dispatch_unit

Interface
REQ-001 Parameter ISSUE_W, default 2: micro-op slots examined per cycle and ALU port count; legal range 1..4.
REQ-002 Parameter NREGS, default 32: number of scoreboard entries; must be a power of two, 16 or 32.
REQ-003 Parameter NWB, default 2: number of writeback ports.
REQ-004 Parameter ZERO_REG_EN, default 0: when 1, entry 0 is never marked busy and never blocks issue.
REQ-005 Derived constants: RID_W = log2(NREGS); OP_W = 3*(RID_W+1)+2. Op layout, MSB first: cls[1:0], dst_v, dst, s0_v, s0, s1_v, s1. cls encoding: 00 ALU, 01 MEM, 1x NOP.
REQ-006 clk  in  1  clock; one clock domain, rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 in_cnt  in  $clog2(ISSUE_W+1)  number of valid ops at the decode-queue head; slot 0 is the oldest.
REQ-009 in_ops  in  ISSUE_W*OP_W  ops; slot i occupies bits [i*OP_W +: OP_W].
REQ-010 flush  in  1  suppresses all issue this cycle.
REQ-011 deq_cnt  out  $clog2(ISSUE_W+1)  ops consumed this cycle; combinational.
REQ-012 alu_ready  in  ISSUE_W  ALU port k can accept an op.
REQ-013 alu_valid  out  ISSUE_W  ALU port k receives an op this cycle.
REQ-014 alu_ops  out  ISSUE_W*OP_W  op sent to each ALU port.
REQ-015 mem_ready  in  1  memory pipe can accept an op.
REQ-016 mem_valid / mem_op  out  1 / OP_W  memory issue.
REQ-017 wb_valid / wb_dst  in  NWB / NWB*RID_W  writeback ports that clear scoreboard entries.
REQ-018 sb_busy  out  NREGS  registered scoreboard.
REQ-019 issued_total / stall_cycles  out  32 / 32  performance counters.

Function
REQ-020 Issue is in order. Slot i issues only if every slot j<i issues in the same cycle and i < in_cnt.
REQ-021 A slot blocks if any of its valid sources or its valid destination is busy in the effective scoreboard.
REQ-022 The effective scoreboard is sb_busy OR the destinations of lower slots issuing this cycle. This enforces intra-group RAW and WAW hazards.
REQ-023 Writebacks do not bypass: a writeback clear becomes visible to the issue logic only in the next cycle.
REQ-024 ALU op in slot i is routed to ALU port i and requires alu_ready[i]. It then drives alu_valid[i]=1 and alu_ops slot i = op.
REQ-025 MEM op requires mem_ready, and no lower slot may have issued MEM this cycle; at most one MEM op issues per cycle.
REQ-026 NOP class ops issue with no port.
REQ-027 For every class, the destination is recorded only if dst_v is set.
REQ-028 Outputs when nothing issues: unissued alu_ops slots and mem_op drive 0; valids drive 0.
REQ-029 deq_cnt = number of issued slots.
REQ-030 When flush=1: deq_cnt=0, no valids, no scoreboard set, counters unchanged. Writeback clears still apply.
REQ-031 Next scoreboard = (sb_busy AND NOT wb_clear_mask) OR issue_set_mask. A set in the same cycle as a clear of the same entry leaves the entry busy (set wins).
REQ-032 A writeback to an entry that is not busy has no effect. Duplicate writebacks on multiple ports in one cycle are legal.
REQ-033 When ZERO_REG_EN=1, bit 0 is masked out of both the set mask and all busy checks.
REQ-034 issued_total increments by deq_cnt each cycle and saturates at 32'hFFFFFFFF.
REQ-035 stall_cycles increments by 1 when in_cnt>0, flush=0 and deq_cnt=0; it saturates at 32'hFFFFFFFF.
REQ-036 Issue latency is zero cycles: the decision is combinational from inputs and the registered scoreboard.

Reset
REQ-037 On reset=1 at a clk edge: sb_busy=0, issued_total=0, stall_cycles=0.
REQ-038 While reset=1, deq_cnt=0 and all valids are 0, regardless of other inputs.
REQ-039 Reset asserted mid-operation discards all busy state; writebacks in that cycle are ignored.

Verification
REQ-040 ISSUE_W=2, empty scoreboard, ALU r1<-r2 and ALU r3<-r4, all ready -> deq_cnt=2, both alu_valid=1; next cycle sb_busy bits 1 and 3 set, issued_total=2.
REQ-041 Slot0 ALU r5<-r6, slot1 ALU r7<-r5 -> deq_cnt=1; slot1 issues only after wb_dst=5 is seen, one cycle after the writeback.
REQ-042 Two MEM ops, mem_ready=1 -> only slot0 issues, mem_valid=1; with mem_ready=0 -> deq_cnt=0 and stall_cycles increments.
REQ-043 Entry 9 busy; same cycle wb_dst=9 and a new op with dst=9 issues -> sb_busy[9] stays 1 next cycle.
REQ-044 ZERO_REG_EN=1, op writes r0 then op reads r0 back-to-back -> both issue, sb_busy[0] stays 0.
REQ-045 flush=1 with in_cnt=2 -> deq_cnt=0, counters hold; a pending wb still clears its entry.

Source files
------------

// File: rtl/dispatch_unit.sv
// In-order multi-slot dispatch with a register scoreboard.
// Routes ALU ops to per-slot ports and at most one MEM op per cycle.
module dispatch_unit #(
  parameter int ISSUE_W     = 2,
  parameter int NREGS       = 32,
  parameter int NWB         = 2,
  parameter int ZERO_REG_EN = 0,
  localparam int RID_W = $clog2(NREGS),
  localparam int OP_W  = 3*(RID_W+1)+2,
  localparam int CNT_W = $clog2(ISSUE_W+1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CNT_W-1:0]         in_cnt,
  input  logic [ISSUE_W*OP_W-1:0]  in_ops,
  input  logic                     flush,
  output logic [CNT_W-1:0]         deq_cnt,
  input  logic [ISSUE_W-1:0]       alu_ready,
  output logic [ISSUE_W-1:0]       alu_valid,
  output logic [ISSUE_W*OP_W-1:0]  alu_ops,
  input  logic                     mem_ready,
  output logic                     mem_valid,
  output logic [OP_W-1:0]          mem_op,
  input  logic [NWB-1:0]           wb_valid,
  input  logic [NWB*RID_W-1:0]     wb_dst,
  output logic [NREGS-1:0]         sb_busy,
  output logic [31:0]              issued_total,
  output logic [31:0]              stall_cycles
);

  localparam logic [NREGS-1:0] ZMASK =
    (ZERO_REG_EN != 0) ? ~NREGS'(1) : {NREGS{1'b1}};

  logic [NREGS-1:0] sb_q, sb_d;
  logic [31:0]      iss_q, iss_d;
  logic [31:0]      stl_q, stl_d;
  logic [32:0]      iss_sum;

  logic [NREGS-1:0] clr_mask, set_mask, eff, dmask;
  logic [CNT_W-1:0] cnt;
  logic             go, mem_used, blk, port_ok;
  logic             is_alu, is_mem;
  logic [OP_W-1:0]  op;
  logic [1:0]       cls;
  logic             dst_v, s0_v, s1_v;
  logic [RID_W-1:0] dst, s0, s1;

  always_comb begin
    clr_mask = '0;
    for (int w = 0; w < NWB; w++) begin
      if (wb_valid[w]) clr_mask[wb_dst[w*RID_W +: RID_W]] = 1'b1;
    end
  end

  // Walk slots oldest-first; the first blocked slot stops the group.
  always_comb begin
    eff       = sb_q & ZMASK;
    set_mask  = '0;
    go        = !reset && !flush;
    mem_used  = 1'b0;
    cnt       = '0;
    alu_valid = '0;
    alu_ops   = '0;
    mem_valid = 1'b0;
    mem_op    = '0;
    op        = '0;
    cls       = '0;
    dst_v     = 1'b0;
    dst       = '0;
    s0_v      = 1'b0;
    s0        = '0;
    s1_v      = 1'b0;
    s1        = '0;
    dmask     = '0;
    blk       = 1'b0;
    port_ok   = 1'b0;
    is_alu    = 1'b0;
    is_mem    = 1'b0;
    for (int i = 0; i < ISSUE_W; i++) begin
      op    = in_ops[i*OP_W +: OP_W];
      cls   = op[OP_W-1 -: 2];
      dst_v = op[3*RID_W+2];
      dst   = op[2*RID_W+2 +: RID_W];
      s0_v  = op[2*RID_W+1];
      s0    = op[RID_W+1 +: RID_W];
      s1_v  = op[RID_W];
      s1    = op[RID_W-1:0];
      dmask = dst_v ? ((NREGS'(1) << dst) & ZMASK) : '0;
      blk   = (s0_v && eff[s0]) ||
              (s1_v && eff[s1]) ||
              (dst_v && eff[dst]);
      is_alu  = 1'b0;
      is_mem  = 1'b0;
      port_ok = 1'b0;
      unique case (1'b1)
        cls[1]: port_ok = 1'b1;
        (cls == 2'b01): begin
          is_mem  = 1'b1;
          port_ok = mem_ready && !mem_used;
        end
        (cls == 2'b00): begin
          is_alu  = 1'b1;
          port_ok = alu_ready[i];
        end
        default: port_ok = 1'b0;
      endcase
      if (go && (CNT_W'(i) < in_cnt) && !blk && port_ok) begin
        cnt      = cnt + CNT_W'(1);
        eff      = eff | dmask;
        set_mask = set_mask | dmask;
        if (is_alu) begin
          alu_valid[i]             = 1'b1;
          alu_ops[i*OP_W +: OP_W]  = op;
        end
        if (is_mem) begin
          mem_valid = 1'b1;
          mem_op    = op;
          mem_used  = 1'b1;
        end
      end else begin
        go = 1'b0;
      end
    end
  end

  always_comb begin
    sb_d    = (sb_q & ~clr_mask) | set_mask;
    iss_sum = {1'b0, iss_q} + 33'(cnt);
    iss_d   = iss_sum[32] ? 32'hFFFF_FFFF : iss_sum[31:0];
    stl_d   = stl_q;
    if ((in_cnt != '0) && !flush && (cnt == '0) &&
        (stl_q != 32'hFFFF_FFFF))
      stl_d = stl_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sb_q  <= '0;
      iss_q <= '0;
      stl_q <= '0;
    end else begin
      sb_q  <= sb_d;
      iss_q <= iss_d;
      stl_q <= stl_d;
    end
  end

  assign deq_cnt      = cnt;
  assign sb_busy      = sb_q;
  assign issued_total = iss_q;
  assign stall_cycles = stl_q;

endmodule

// File: tb/tb_dispatch_unit.sv
// Directed bench for dispatch_unit: driver queues expected per-cycle
// responses, a negedge monitor pops and compares them.
module tb_dispatch_unit;

  localparam logic [1:0] ALU = 2'b00;
  localparam logic [1:0] MEM = 2'b01;
  localparam logic [1:0] NOP = 2'b10;

  logic        clk = 1'b0;
  logic        reset, zreset, flush, mem_ready;
  logic [1:0]  in_cnt, alu_ready, wb_valid;
  logic [39:0] in_ops;
  logic [9:0]  wb_dst;

  logic [1:0]  deq_cnt, alu_valid;
  logic [39:0] alu_ops;
  logic        mem_valid;
  logic [19:0] mem_op;
  logic [31:0] sb_busy, issued_total, stall_cycles;

  logic [1:0]  z_deq, z_av;
  logic [39:0] z_ops;
  logic        z_mv;
  logic [19:0] z_mop;
  logic [31:0] z_sb, z_iss, z_stl;

  always #5 clk = ~clk;

  dispatch_unit u_dut (
    .clk(clk), .reset(reset), .in_cnt(in_cnt), .in_ops(in_ops),
    .flush(flush), .deq_cnt(deq_cnt), .alu_ready(alu_ready),
    .alu_valid(alu_valid), .alu_ops(alu_ops), .mem_ready(mem_ready),
    .mem_valid(mem_valid), .mem_op(mem_op), .wb_valid(wb_valid),
    .wb_dst(wb_dst), .sb_busy(sb_busy), .issued_total(issued_total),
    .stall_cycles(stall_cycles)
  );

  dispatch_unit #(.ZERO_REG_EN(1)) u_zdut (
    .clk(clk), .reset(zreset), .in_cnt(in_cnt), .in_ops(in_ops),
    .flush(flush), .deq_cnt(z_deq), .alu_ready(alu_ready),
    .alu_valid(z_av), .alu_ops(z_ops), .mem_ready(mem_ready),
    .mem_valid(z_mv), .mem_op(z_mop), .wb_valid(wb_valid),
    .wb_dst(wb_dst), .sb_busy(z_sb), .issued_total(z_iss),
    .stall_cycles(z_stl)
  );

  typedef struct {
    int          idx;
    logic [1:0]  deq;
    logic [1:0]  av;
    logic [39:0] aops;
    logic        mv;
    logic [19:0] mop;
    logic [31:0] sb;
    logic [31:0] iss;
    logic [31:0] stl;
    logic [1:0]  zdeq;
    logic [31:0] zsb;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   step_n = 0;

  function automatic logic [19:0] mk(
    input logic [1:0] c, input logic dv, input logic [4:0] d,
    input logic av, input logic [4:0] a,
    input logic bv, input logic [4:0] b);
    return {c, dv, d, av, a, bv, b};
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL step%0d %s actual=%h required=%h", idx, nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("deq_cnt", e.idx, 64'(deq_cnt), 64'(e.deq));
      chk("alu_valid", e.idx, 64'(alu_valid), 64'(e.av));
      chk("alu_ops", e.idx, 64'(alu_ops), 64'(e.aops));
      chk("mem_valid", e.idx, 64'(mem_valid), 64'(e.mv));
      chk("mem_op", e.idx, 64'(mem_op), 64'(e.mop));
      chk("sb_busy", e.idx, 64'(sb_busy), 64'(e.sb));
      chk("issued_total", e.idx, 64'(issued_total), 64'(e.iss));
      chk("stall_cycles", e.idx, 64'(stall_cycles), 64'(e.stl));
      chk("z_deq_cnt", e.idx, 64'(z_deq), 64'(e.zdeq));
      chk("z_sb_busy", e.idx, 64'(z_sb), 64'(e.zsb));
    end
  end

  task automatic step(
    input logic rst, input logic zr, input logic fl,
    input logic [1:0] cnt, input logic [19:0] o0, input logic [19:0] o1,
    input logic [1:0] ar, input logic mr,
    input logic [1:0] wv, input logic [4:0] w0, input logic [4:0] w1,
    input logic [1:0] e_deq, input logic [1:0] e_av, input logic e_mv,
    input logic [31:0] e_sb, input logic [31:0] e_iss,
    input logic [31:0] e_stl, input logic [1:0] e_zdeq,
    input logic [31:0] e_zsb);
    exp_t e;
    reset     = rst;
    zreset    = zr;
    flush     = fl;
    in_cnt    = cnt;
    in_ops    = {o1, o0};
    alu_ready = ar;
    mem_ready = mr;
    wb_valid  = wv;
    wb_dst    = {w1, w0};
    e.idx  = step_n;
    e.deq  = e_deq;
    e.av   = e_av;
    e.aops = {(e_av[1] ? o1 : 20'h0), (e_av[0] ? o0 : 20'h0)};
    e.mv   = e_mv;
    e.mop  = e_mv ? o0 : 20'h0;
    e.sb   = e_sb;
    e.iss  = e_iss;
    e.stl  = e_stl;
    e.zdeq = e_zdeq;
    e.zsb  = e_zsb;
    exp_q.push_back(e);
    step_n++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [19:0] z;
    z = 20'h0;
    reset = 1'b1; zreset = 1'b1; flush = 1'b0;
    in_cnt = 2'd0; in_ops = '0; alu_ready = 2'b11; mem_ready = 1'b1;
    wb_valid = 2'b00; wb_dst = '0;
    @(posedge clk);
    #1;
    // reset holds off issue
    step(1,1,0, 2, mk(ALU,1,1,1,2,0,0), mk(ALU,1,3,1,4,0,0), 2'b11,1,
         2'b00,0,0, 0,2'b00,0, 32'h0,0,0, 0,32'h0);
    // dual independent ALU issue
    step(0,1,0, 2, mk(ALU,1,1,1,2,0,0), mk(ALU,1,3,1,4,0,0), 2'b11,1,
         2'b00,0,0, 2,2'b11,0, 32'h0,0,0, 0,32'h0);
    // intra-group RAW on r5
    step(0,1,0, 2, mk(ALU,1,5,1,6,0,0), mk(ALU,1,7,1,5,0,0), 2'b11,1,
         2'b00,0,0, 1,2'b01,0, 32'h0000_000A,2,0, 0,32'h0);
    // wb r5 not bypassed
    step(0,1,0, 1, mk(ALU,1,7,1,5,0,0), z, 2'b11,1,
         2'b01,5,0, 0,2'b00,0, 32'h0000_002A,3,0, 0,32'h0);
    step(0,1,0, 1, mk(ALU,1,7,1,5,0,0), z, 2'b11,1,
         2'b00,0,0, 1,2'b01,0, 32'h0000_000A,3,1, 0,32'h0);
    // two MEM ops: only one per cycle
    step(0,1,0, 2, mk(MEM,0,0,1,10,0,0), mk(MEM,0,0,1,11,0,0), 2'b11,1,
         2'b00,0,0, 1,2'b00,1, 32'h0000_008A,4,1, 0,32'h0);
    step(0,1,0, 2, mk(MEM,0,0,1,11,0,0), mk(MEM,0,0,1,12,0,0), 2'b11,0,
         2'b00,0,0, 0,2'b00,0, 32'h0000_008A,5,1, 0,32'h0);
    // ALU port not ready; dual wb clears r1,r3
    step(0,1,0, 1, mk(ALU,1,12,1,13,0,0), z, 2'b00,1,
         2'b11,1,3, 0,2'b00,0, 32'h0000_008A,5,2, 0,32'h0);
    // make r9 busy, NOP takes no port
    step(0,1,0, 2, mk(ALU,1,9,1,2,0,0), mk(NOP,0,0,0,0,0,0), 2'b11,1,
         2'b00,0,0, 2,2'b01,0, 32'h0000_0080,5,3, 0,32'h0);
    // WAW on busy r9 while wb clears it
    step(0,1,0, 1, mk(ALU,1,9,1,2,0,0), z, 2'b11,1,
         2'b10,0,9, 0,2'b00,0, 32'h0000_0280,7,3, 0,32'h0);
    // issue dst r9 with concurrent wb r9: set wins
    step(0,1,0, 1, mk(ALU,1,9,1,2,0,0), z, 2'b11,1,
         2'b01,9,0, 1,2'b01,0, 32'h0000_0080,7,4, 0,32'h0);
    // intra-group WAW on r20
    step(0,1,0, 2, mk(ALU,1,20,1,21,0,0), mk(NOP,1,20,0,0,0,0), 2'b11,1,
         2'b00,0,0, 1,2'b01,0, 32'h0000_0280,8,4, 0,32'h0);
    // flush: nothing issues, wb r7 still clears
    step(0,1,1, 2, mk(ALU,1,22,1,23,0,0), mk(ALU,1,24,1,25,0,0), 2'b11,1,
         2'b01,7,0, 0,2'b00,0, 32'h0010_0280,9,4, 0,32'h0);
    step(0,1,0, 0, z, z, 2'b11,1,
         2'b00,0,0, 0,2'b00,0, 32'h0010_0200,9,4, 0,32'h0);
    // blocked slot0 stops independent slot1
    step(0,1,0, 2, mk(ALU,1,26,1,9,0,0), mk(ALU,1,27,1,28,0,0), 2'b11,1,
         2'b00,0,0, 0,2'b00,0, 32'h0010_0200,9,4, 0,32'h0);
    // reset mid-operation with wb present
    step(1,1,0, 2, mk(ALU,1,29,1,30,0,0), z, 2'b11,1,
         2'b01,9,0, 0,2'b00,0, 32'h0010_0200,9,5, 0,32'h0);
    step(0,1,0, 0, z, z, 2'b11,1,
         2'b00,0,0, 0,2'b00,0, 32'h0,0,0, 0,32'h0);
    // zero-register instance: r0 write then read
    step(1,0,0, 2, mk(ALU,1,0,1,2,0,0), mk(ALU,1,4,1,0,0,0), 2'b11,1,
         2'b00,0,0, 0,2'b00,0, 32'h0,0,0, 2,32'h0);
    step(1,0,0, 1, mk(ALU,1,0,1,0,0,0), z, 2'b11,1,
         2'b00,0,0, 0,2'b00,0, 32'h0,0,0, 1,32'h0000_0010);
    step(1,0,0, 0, z, z, 2'b11,1,
         2'b00,0,0, 0,2'b00,0, 32'h0,0,0, 0,32'h0000_0010);
    for (int k = 0; k < 10; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
